top_atanh_fpsingle: RTL and testbench

//  Inverse of the tanh block: single-precision atanh(x) by table lookup for |x|<1.

---
 rtl/top_atanh_fpsingle.sv | 162 ++++++++++++++++
 tb/tb_top_atanh_fpsingle.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/top_atanh_fpsingle.sv
// top_atanh_fpsingle: streaming single-precision atanh(x) for |x|<1 through a 2^ADDR_WIDTH-entry table.
// Optional macro ATANH_BYPASS_SMALL_EN: nonzero |x| < 2^-ADDR_WIDTH passes x through unchanged.
module top_atanh_fpsingle #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num_entrada,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] num_salida
);
    localparam int ROM_DEPTH = 1 << ADDR_WIDTH;
    localparam int FRAC_W    = DATA_WIDTH - 3;
    localparam int RND_SH    = 55 - FRAC_W;

    // Table word round(atanh(a/ROM_DEPTH) * 2^FRAC_W), evaluated at elaboration:
    // 0.5*ln((D+a)/(D-a)) built from an integer bit-serial log2 times ln2.
    function automatic logic [DATA_WIDTH-1:0] atanh_word(input int a);
        logic [63:0] y;
        logic [63:0] lg;
        logic [63:0] prod;
        int          n;
        y = (64'(ROM_DEPTH + a) << 30) / 64'(ROM_DEPTH - a);
        n = 0;
        while (y >= (64'd2 << 30)) begin
            y = y >> 1;
            n = n + 1;
        end
        lg = 64'(n);
        for (int i = 0; i < 30; i++) begin
            y  = (y * y) >> 30;
            lg = lg << 1;
            if (y >= (64'd2 << 30)) begin
                y  = y >> 1;
                lg = lg | 64'd1;
            end
        end
        prod = lg * 64'd11629080;
        atanh_word = DATA_WIDTH'((prod + (64'd1 << (RND_SH - 1))) >> RND_SH);
    endfunction

    logic [DATA_WIDTH-1:0] rom_w [ROM_DEPTH];

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] WORD = atanh_word(g);
        assign rom_w[g] = WORD;
    end

    logic                  adv_s;
    logic                  v1_r, v2_r, v3_r;
    logic [31:0]           x1_r;
    logic                  byp_s, byp2_r, sign2_r;
    logic [31:0]           byp_val_s, byp_val2_r;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [8:0]            sh_s;
    logic [DATA_WIDTH-1:0] q2_r;
    logic [4:0]            pos_s;
    logic [7:0]            exp_f_s;
    logic [22:0]           mant_s;
    logic [30:0]           f2f_s;
    logic [31:0]           res_s, res3_r;

    assign adv_s    = !out_valid | out_ready;
    assign in_ready = adv_s;

    // S1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            x1_r <= 32'h0;
        end else if (adv_s) begin
            v1_r <= in_valid;
            x1_r <= num_entrada;
        end
    end

    // S2 decode: special classes override the table; otherwise truncate |x| to a table address
    always_comb begin
        byp_s     = 1'b0;
        byp_val_s = 32'h0;
        sh_s      = 9'(127 + 23 - ADDR_WIDTH) - {1'b0, x1_r[30:23]};
        if (x1_r[30:23] > 8'd127 || (x1_r[30:23] == 8'd127 && x1_r[22:0] != 23'd0)) begin
            byp_s     = 1'b1;
            byp_val_s = 32'h7FC00000;
        end else if (x1_r[30:23] == 8'd127) begin
            byp_s     = 1'b1;
            byp_val_s = {x1_r[31], 31'h7F800000};
        end else if (x1_r[30:23] == 8'd0) begin
            byp_s     = 1'b1;
            byp_val_s = {x1_r[31], 31'h0};
`ifdef ATANH_BYPASS_SMALL_EN
        end else if (x1_r[30:23] < 8'(127 - ADDR_WIDTH)) begin
            byp_s     = 1'b1;
            byp_val_s = x1_r;
`endif
        end else begin
            byp_s     = 1'b0;
            byp_val_s = 32'h0;
        end
        if (sh_s >= 9'd24) begin
            addr_s = '0;
        end else begin
            addr_s = ADDR_WIDTH'({1'b1, x1_r[22:0]} >> sh_s);
        end
    end

    // S2 register: table read plus class/sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r       <= 1'b0;
            byp2_r     <= 1'b0;
            byp_val2_r <= 32'h0;
            sign2_r    <= 1'b0;
            q2_r       <= '0;
        end else if (adv_s) begin
            v2_r       <= v1_r;
            byp2_r     <= byp_s;
            byp_val2_r <= byp_val_s;
            sign2_r    <= x1_r[31];
            q2_r       <= rom_w[addr_s];
        end
    end

    // S3 fixed-to-float: leading-one position sets exponent, bits below it form the mantissa
    always_comb begin
        pos_s = 5'd0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos_s = q2_r[i] ? 5'(i) : pos_s;
        end
        exp_f_s = 8'(127 - FRAC_W) + {3'b0, pos_s};
        mant_s  = 23'({23'd0, q2_r} << (5'd23 - pos_s));
        if (q2_r == '0) begin
            f2f_s = 31'h0;
        end else begin
            f2f_s = {exp_f_s, mant_s};
        end
        if (byp2_r) begin
            res_s = byp_val2_r;
        end else begin
            res_s = {sign2_r, f2f_s};
        end
    end

    // S3 and S4 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r       <= 1'b0;
            res3_r     <= 32'h0;
            out_valid  <= 1'b0;
            num_salida <= 32'h0;
        end else if (adv_s) begin
            v3_r       <= v2_r;
            res3_r     <= res_s;
            out_valid  <= v3_r;
            num_salida <= res3_r;
        end
    end
endmodule

// File: tb/tb_top_atanh_fpsingle.sv
// Directed bench for top_atanh_fpsingle: classes, latency, stall/backpressure, async reset.
module tb_top_atanh_fpsingle;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num_entrada;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] num_salida;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    top_atanh_fpsingle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .num_entrada(num_entrada),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .num_salida (num_salida)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: accept edge counts as cycle 1, result visible after the 4th edge
    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] expv);
        in_valid    = 1'b1;
        num_entrada = x;
        out_ready   = 1'b1;
        #1;
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid    = 1'b0;
        num_entrada = 32'h0;
        step();
        step();
        check_val({tag, "_early"}, 32'(out_valid), 32'd0);
        step();
        check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_val(tag, num_salida, expv);
        step();
    endtask

    logic [31:0] vec  [8];
    logic [31:0] expd [8];
    logic [31:0] prev_out;
    logic        prev_stall;
    logic        acc;
    int          sent;
    int          rcvd;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        num_entrada = 32'h0;
        out_ready   = 1'b1;
        step();
        step();
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_num_salida", num_salida, 32'h0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        run_one("half",     32'h3F000000, 32'h3F0D0000);
        run_one("neg_half", 32'hBF000000, 32'hBF0D0000);
        run_one("neg_zero", 32'h80000000, 32'h80000000);
        run_one("pos_one",  32'h3F800000, 32'h7F800000);
        run_one("neg_one",  32'hBF800000, 32'hFF800000);
        run_one("gt_one",   32'h3FC00000, 32'h7FC00000);
        run_one("nan_in",   32'h7FC00001, 32'h7FC00000);
        run_one("pos_inf",  32'h7F800000, 32'h7FC00000);
        run_one("quarter",  32'h3E800000, 32'h3E820000);
        run_one("three_q",  32'h3F400000, 32'h3F790000);
        run_one("max_lt1",  32'h3F7FFFFF, 32'h40740000);
        run_one("denorm",   32'h80400000, 32'h80000000);
        run_one("two_m10",  32'h3A800000, 32'h00000000);
`ifdef ATANH_BYPASS_SMALL_EN
        run_one("two_m11",  32'h3A000000, 32'h3A000000);
`else
        run_one("two_m11",  32'h3A000000, 32'h00000000);
`endif

        // Streaming with backpressure in cycles 6..9
        vec  = '{32'h3F000000, 32'hBF000000, 32'h00000000, 32'h80000000,
                 32'h3F800000, 32'hBF800000, 32'h3FC00000, 32'h3E800000};
        expd = '{32'h3F0D0000, 32'hBF0D0000, 32'h00000000, 32'h80000000,
                 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3E820000};
        sent       = 0;
        rcvd       = 0;
        prev_stall = 1'b0;
        prev_out   = 32'h0;
        for (int c = 1; c <= 40 && rcvd < 8; c++) begin
            in_valid    = (sent < 8);
            num_entrada = (sent < 8) ? vec[sent] : 32'h0;
            out_ready   = !(c >= 6 && c <= 9);
            #1;
            if (prev_stall) begin
                check_val("s4_hold_vld", 32'(out_valid), 32'd1);
                check_val("s4_hold_data", num_salida, prev_out);
            end
            if (out_valid && !out_ready) begin
                check_val("s4_stall_rdy", 32'(in_ready), 32'd0);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_val($sformatf("s4_seq%0d", rcvd), num_salida, expd[rcvd]);
                rcvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = num_salida;
            step();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("s4_sent", 32'(sent), 32'd8);
        check_val("s4_rcvd", 32'(rcvd), 32'd8);
        for (int i = 0; i < 3; i++) begin
            check_val("s4_no_dup", 32'(out_valid), 32'd0);
            step();
        end

        // Async reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            num_entrada = vec[i];
            step();
        end
        in_valid = 1'b0;
        step();
        check_val("rst_pre_vld", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_vld", 32'(out_valid), 32'd0);
        check_val("rst_async_data", num_salida, 32'h0);
        check_val("rst_async_rdy", 32'(in_ready), 32'd1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("rst_no_stale", 32'(out_valid), 32'd0);
        end
        run_one("rst_after", 32'h3F000000, 32'h3F0D0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
